// File: rtl/ram_lat_arb.sv
// Multi-channel variable-latency RAM model: round-robin arbitration across NCH requesters,
// programmable access latency, byte-lane writes and out-of-range protection on one shared array.
module ram_lat_arb #(
  parameter int          NCH   = 2,
  parameter int          DW    = 32,
  parameter int          AW    = 16,
  parameter int          DEPTH = 16384,
  parameter int          LAT   = 4,
  parameter logic [31:0] BAD   = 32'hBAD1BAD1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NCH-1:0]      ren,
  input  logic [NCH-1:0]      wen,
  input  logic [NCH*AW-1:0]   addr,
  input  logic [NCH*DW-1:0]   store,
  input  logic [NCH*DW/8-1:0] byteen,
  output logic [NCH*DW-1:0]   load,
  output logic [NCH*2-1:0]    state,
  output logic [NCH-1:0]      grant
);
  localparam int NB   = DW / 8;
  localparam int OFF  = (NB > 1) ? $clog2(NB) : 0;
  localparam int WW   = AW - OFF;
  localparam int MIW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NREP = (DW + 31) / 32;
  localparam logic [NREP*32-1:0] BAD_REP = {NREP{BAD}};
  localparam logic [DW-1:0]      BAD_W   = BAD_REP[DW-1:0];
  localparam logic [3:0]         LAT_C   = 4'(LAT);
  localparam logic [31:0]        DEPTH_C = 32'(DEPTH);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  logic [DW-1:0] mem [DEPTH];

  logic          own_vld_q, own_vld_d;
  logic [CW-1:0] own_q, own_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic          lat_ren_q, lat_ren_d;
  logic          lat_wen_q, lat_wen_d;

  logic [AW-1:0]  ch_addr  [NCH];
  logic [DW-1:0]  ch_store [NCH];
  logic [NB-1:0]  ch_be    [NCH];
  logic [NCH-1:0] vreq, match, acc;

  logic [WW-1:0]  lat_word;
  logic [MIW-1:0] midx;
  logic           in_rng;
  logic [DW-1:0]  rd_dat;
  logic           rel, mem_we;
  logic [CW-1:0]  cand;

  // The array is addressed by the latched request; it equals the live one during ACCESS.
  assign lat_word = lat_addr_q[AW-1:OFF];
  assign midx     = lat_word[MIW-1:0];
  assign in_rng   = 32'(lat_word) < DEPTH_C;
  assign rd_dat   = mem[midx];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_addr[i]  = addr[i*AW +: AW];
    assign ch_store[i] = store[i*DW +: DW];
    assign ch_be[i]    = byteen[i*NB +: NB];
    assign vreq[i]     = ren[i] ^ wen[i];
    assign grant[i]    = own_vld_q && (own_q == CW'(i));
    assign match[i]    = grant[i] && (ch_addr[i] == lat_addr_q) &&
                         (ren[i] == lat_ren_q) && (wen[i] == lat_wen_q);
    assign acc[i]      = match[i] && (cnt_q == LAT_C);
    assign state[i*2 +: 2] = (!nRST || !(ren[i] || wen[i])) ? FREE   :
                             (ren[i] && wen[i])             ? ERROR  :
                             acc[i]                         ? ACCESS : BUSY;
    assign load[i*DW +: DW] = (acc[i] && in_rng) ? rd_dat : BAD_W;
  end

  always_comb begin
    own_vld_d  = own_vld_q;
    own_d      = own_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_ren_d  = lat_ren_q;
    lat_wen_d  = lat_wen_q;
    rel        = 1'b0;
    mem_we     = 1'b0;
    cand       = '0;
    if (own_vld_q) begin
      if (!vreq[own_q]) begin
        rel = 1'b1;
      end else if (|acc) begin
        rel    = 1'b1;
        rr_d   = (own_q == CW'(NCH - 1)) ? '0 : own_q + 1'b1;
        mem_we = lat_wen_q && in_rng;
      end else if (|match) begin
        if (cnt_q != LAT_C) cnt_d = cnt_q + 4'd1;
      end else begin
        lat_addr_d = ch_addr[own_q];
        lat_ren_d  = ren[own_q];
        lat_wen_d  = wen[own_q];
        cnt_d      = '0;
      end
    end
    // A released slot is re-arbitrated on the same edge, starting from the updated pointer.
    if (!own_vld_q || rel) begin
      own_vld_d = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        cand = CW'((int'(rr_d) + k) % NCH);
        if (!own_vld_d && vreq[cand]) begin
          own_vld_d  = 1'b1;
          own_d      = cand;
          lat_addr_d = ch_addr[cand];
          lat_ren_d  = ren[cand];
          lat_wen_d  = wen[cand];
          cnt_d      = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      own_vld_q  <= 1'b0;
      own_q      <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_ren_q  <= 1'b0;
      lat_wen_q  <= 1'b0;
    end else begin
      own_vld_q  <= own_vld_d;
      own_q      <= own_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_ren_q  <= lat_ren_d;
      lat_wen_q  <= lat_wen_d;
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (ch_be[own_q][b]) mem[midx][b*8 +: 8] <= ch_store[own_q][b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_lat_arb.sv
// Bench for ram_lat_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model; a second LAT=0, 3-channel instance covers the latency floor.
module tb_ram_lat_arb;
  localparam int NCH = 2, DW = 32, AW = 16, DEPTH = 64, LAT = 4;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [NCH-1:0]    ren = '0, wen = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] store = '0;
  logic [NCH*4-1:0]  byteen = '0;
  logic [NCH*DW-1:0] load;
  logic [NCH*2-1:0]  state;
  logic [NCH-1:0]    grant;

  logic [2:0]  r2 = '0, w2 = '0;
  logic [47:0] a2 = '0;
  logic [95:0] s2 = '0;
  logic [11:0] b2 = '0;
  logic [95:0] l2;
  logic [5:0]  st2;
  logic [2:0]  g2;

  always #5 CLK = ~CLK;

  ram_lat_arb #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .LAT(LAT), .BAD(BAD)) u_dut (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .store(store),
    .byteen(byteen), .load(load), .state(state), .grant(grant));

  ram_lat_arb #(.NCH(3), .DW(32), .AW(16), .DEPTH(16), .LAT(0), .BAD(BAD)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .ren(r2), .wen(w2), .addr(a2), .store(s2),
    .byteen(b2), .load(l2), .state(st2), .grant(g2));

  // Reference model: one transaction in flight, aged in cycles since it was latched.
  logic [31:0]   mm [DEPTH];
  bit            mk [DEPTH];
  int            m_own = -1, m_rr = 0, m_t0 = 0, cyc = 0;
  logic          m_r = 1'b0, m_w = 1'b0;
  logic [AW-1:0] m_a = '0;

  int n_chk = 0, n_fail = 0;
  logic [1:0]     obs_st [NCH];
  logic [31:0]    obs_ld [NCH];
  logic [NCH-1:0] obs_gr;
  logic [1:0]     obs2_st [3];
  logic [31:0]    obs2_ld [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int wrd(input logic [AW-1:0] a);
    return int'(a) / 4;
  endfunction

  function automatic bit same(input int ch);
    return ren[ch] == m_r && wen[ch] == m_w && addr[ch*AW +: AW] == m_a;
  endfunction

  function automatic logic [1:0] exp_st(input int ch);
    if (!nRST || (!ren[ch] && !wen[ch])) return S_FREE;
    if (ren[ch] && wen[ch]) return S_ERR;
    if (m_own == ch && same(ch) && (cyc - m_t0) >= LAT) return S_ACC;
    return S_BUSY;
  endfunction

  task automatic latch(input int ch);
    m_r  = ren[ch];
    m_w  = wen[ch];
    m_a  = addr[ch*AW +: AW];
    m_t0 = cyc + 1;
  endtask

  task automatic model_reset();
    m_own = -1;
    m_rr  = 0;
  endtask

  task automatic model_edge();
    bit rel;
    int w;
    rel = 1'b0;
    if (!nRST) begin
      model_reset();
    end else begin
      if (m_own >= 0) begin
        if (ren[m_own] == wen[m_own]) rel = 1'b1;
        else if (same(m_own) && (cyc - m_t0) >= LAT) begin
          rel = 1'b1;
          w = wrd(m_a);
          if (m_w && w < DEPTH) begin
            for (int b = 0; b < 4; b++)
              if (byteen[m_own*4 + b]) mm[w][b*8 +: 8] = store[m_own*DW + b*8 +: 8];
            mk[w] = mk[w] || (byteen[m_own*4 +: 4] == 4'hF);
          end
          m_rr = (m_own + 1) % NCH;
        end else if (!same(m_own)) latch(m_own);
      end
      if (m_own < 0 || rel) begin
        m_own = -1;
        for (int k = 0; k < NCH; k++) begin
          if (m_own < 0 && (ren[(m_rr + k) % NCH] ^ wen[(m_rr + k) % NCH])) begin
            m_own = (m_rr + k) % NCH;
            latch(m_own);
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [1:0]     est;
    logic [31:0]    eld;
    logic [NCH-1:0] egr;
    int             w;
    for (int ch = 0; ch < NCH; ch++) begin
      obs_st[ch] = state[ch*2 +: 2];
      obs_ld[ch] = load[ch*DW +: DW];
      est = exp_st(ch);
      w   = wrd(addr[ch*AW +: AW]);
      chk($sformatf("state%0d", ch), obs_st[ch], est);
      eld = BAD;
      if (est == S_ACC && w < DEPTH) eld = mm[w];
      if (est != S_ACC || w >= DEPTH || mk[w]) chk($sformatf("load%0d", ch), obs_ld[ch], eld);
    end
    egr = '0;
    if (m_own >= 0) egr[m_own] = 1'b1;
    obs_gr = grant;
    chk("grant", obs_gr, egr);
    for (int ch = 0; ch < 3; ch++) begin
      obs2_st[ch] = st2[ch*2 +: 2];
      obs2_ld[ch] = l2[ch*32 +: 32];
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    ren = '0; wen = '0; r2 = '0; w2 = '0;
    nRST = 1'b0;
    model_reset();
    tick();
    nRST = 1'b1;
  endtask

  task automatic set_req(input int ch, input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    ren[ch] = r;
    wen[ch] = w;
    addr[ch*AW +: AW] = a;
    store[ch*DW +: DW] = d;
    byteen[ch*4 +: 4] = be;
  endtask

  task automatic xact(input int ch, input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] be, output int n);
    n = 0;
    set_req(ch, r, w, a, d, be);
    do begin
      tick();
      n++;
    end while (obs_st[ch] != S_ACC && n < 60);
    chk("xact_done", obs_st[ch], S_ACC);
    ren[ch] = 1'b0;
    wen[ch] = 1'b0;
  endtask

  task automatic new_req(input int ch);
    int k;
    bit r;
    k = $urandom_range(0, 99);
    r = 1'($urandom_range(0, 1));
    if (k < 25) set_req(ch, 1'b0, 1'b0, '0, '0, '0);
    else set_req(ch, (k < 30) ? 1'b1 : r, (k < 30) ? 1'b1 : !r,
                 AW'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3)),
                 $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_ch;
    logic [31:0] old;
    for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = 1'b0; end

    // Reset state is checked by the tick inside do_reset.
    do_reset();
    for (int i = 0; i < DEPTH; i++) xact(0, 1'b0, 1'b1, AW'(i * 4), $urandom, 4'hF, n);

    // Uncontended read: BUSY 0-4, ACCESS 5, grant from cycle 1.
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0010, '0, '0);
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk("t1_state", obs_st[0], (c == 5) ? S_ACC : S_BUSY);
      chk("t1_grant", obs_gr, (c == 0) ? 2'b00 : 2'b01);
      chk("t1_load", obs_ld[0], (c == 5) ? mm[4] : BAD);
    end
    ren = '0;
    tick();

    // Byte-lane write merge.
    xact(1, 1'b0, 1'b1, 16'h0020, 32'h11223344, 4'hF, n);
    xact(1, 1'b0, 1'b1, 16'h0020, 32'hDEADBEEF, 4'b0101, n);
    xact(1, 1'b1, 1'b0, 16'h0020, '0, '0, n);
    chk("t2_merge", obs_ld[1], 32'h11AD33EF);

    // Contention from rr=0, then ch0 re-asserts and is served after ch1.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      set_req(0, (c <= 5 || c >= 7), 1'b0, 16'h0018, '0, '0);
      set_req(1, (c <= 10), 1'b0, 16'h001C, '0, '0);
      tick();
      if (c == 5)  chk("t3_ch0_acc", obs_st[0], S_ACC);
      if (c == 6)  chk("t3_grant1", obs_gr, 2'b10);
      if (c == 9)  chk("t3_ch1_busy", obs_st[1], S_BUSY);
      if (c == 10) chk("t3_ch1_acc", obs_st[1], S_ACC);
      if (c == 11) chk("t3_grant0", obs_gr, 2'b01);
      if (c == 15) chk("t3_ch0_acc2", obs_st[0], S_ACC);
    end
    ren = '0;
    tick();

    // Address change mid-wait restarts the count.
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      set_req(0, 1'b1, 1'b0, (c < 3) ? 16'h0010 : 16'h0014, '0, '0);
      tick();
      if (c == 7) chk("t4_busy", obs_st[0], S_BUSY);
      if (c == 8) begin
        chk("t4_acc", obs_st[0], S_ACC);
        chk("t4_load", obs_ld[0], mm[5]);
      end
    end
    ren = '0;
    tick();

    // ERROR requester is never granted; the other channel proceeds.
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0010, '0, '0);
    set_req(1, 1'b1, 1'b0, 16'h0008, '0, '0);
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk("t5_err", obs_st[0], S_ERR);
      chk("t5_nogrant", obs_gr[0], 1'b0);
      chk("t5_errload", obs_ld[0], BAD);
      if (c == 5) chk("t5_ch1_acc", obs_st[1], S_ACC);
    end
    ren = '0; wen = '0;
    tick();

    // Asynchronous reset aborts an in-flight write.
    do_reset();
    old = mm[3];
    set_req(0, 1'b0, 1'b1, 16'h000C, 32'hCAFEF00D, 4'hF);
    tick(); tick(); tick();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("t6_state", state, '0);
    chk("t6_grant", grant, '0);
    chk("t6_load", load, {BAD, BAD});
    tick();
    wen = '0;
    nRST = 1'b1;
    tick();
    xact(0, 1'b1, 1'b0, 16'h000C, '0, '0, n);
    chk("t6_latency", n, LAT + 2);
    chk("t6_unchanged", obs_ld[0], old);

    // Out of range: ACCESS with BAD data, write suppressed (word 64 must not alias word 0).
    do_reset();
    old = mm[0];
    xact(0, 1'b1, 1'b0, 16'h0100, '0, '0, n);
    chk("t7_latency", n, LAT + 2);
    chk("t7_load", obs_ld[0], BAD);
    xact(0, 1'b0, 1'b1, 16'h0100, 32'h0BADF00D, 4'hF, n);
    xact(0, 1'b1, 1'b0, 16'h0000, '0, '0, n);
    chk("t7_noalias", obs_ld[0], old);

    // LAT=0, three channels: ACCESS in cycle 1, then strict rotation.
    do_reset();
    w2[2] = 1'b1; a2[32 +: 16] = 16'h0008; s2[64 +: 32] = 32'h12345678; b2[8 +: 4] = 4'hF;
    tick();
    chk("l0_c0_busy", obs2_st[2], S_BUSY);
    tick();
    chk("l0_c1_acc", obs2_st[2], S_ACC);
    w2 = '0;
    tick();
    r2 = 3'b111;
    a2 = {16'h0008, 16'h0008, 16'h0008};
    for (int c = 0; c <= 4; c++) begin
      tick();
      acc_ch = (c == 0) ? -1 : (c - 1) % 3;
      for (int ch = 0; ch < 3; ch++)
        chk($sformatf("l0_rr%0d_ch%0d", c, ch), obs2_st[ch], (ch == acc_ch) ? S_ACC : S_BUSY);
      if (c == 3) chk("l0_load", obs2_ld[2], 32'h12345678);
    end
    r2 = '0;

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int ch = 0; ch < NCH; ch++)
        if (obs_st[ch] == S_ACC || $urandom_range(0, 24) == 0) new_req(ch);
      if (c % 700 == 350) begin
        nRST = 1'b0;
        model_reset();
        tick();
        nRST = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
